wb_fsmc_fifo_slave: RTL
=======================

Name: wb_fsmc_fifo_slave

Overview:
- Wishbone slave that sits directly downstream of the FSMC-to-Wishbone bridge.
- Gives the external MCU a half-word-friendly mailbox into the FPGA fabric:
  - a TX FIFO (host to fabric), drained by a valid/ready stream;
  - an RX FIFO (fabric to host), filled by a valid/ready stream.
- Also provides status and control registers.
- Combines 16-bit accesses (sel 0011 / 1100) into 32-bit FIFO words.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth. Both FIFOs hold 2^DEPTH_LOG2 32-bit entries.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_adr_i  in  32  Wishbone address
- wb_dat_i  in  32  Wishbone write data
- wb_dat_o  out  32  Wishbone read data
- wb_sel_i  in  4  byte selects
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- tx_dat  out  32  TX FIFO head
- tx_vld  out  1  TX FIFO not empty
- tx_rdy  in  1  fabric accepts tx_dat
- rx_dat  in  32  fabric data into RX FIFO
- rx_vld  in  1  rx_dat valid
- rx_rdy  out  1  RX FIFO not full

Behaviour:
- Reset (asynchronous, active-high rst), all outputs 0:
  - wb_ack_o=0, wb_dat_o=0, tx_vld=0, tx_dat=0.
  - rx_rdy=0 while rst is high; 1 after release (RX FIFO empty).
  - Both FIFOs empty, hold register 0, sticky flags 0.
- Wishbone handshake:
  - A request is accepted at a rising edge where cyc&stb&~wb_ack_o.
  - wb_ack_o is high for exactly the next cycle; wb_dat_o is registered and valid in that cycle.
  - Single-cycle latency; no wait states; never error.
  - While ack is high, stb is ignored, because the bridge drops stb only after seeing ack.
- Address decode:
  - wb_adr_i[1:0] selects the register. wb_adr_i[31:2] must be 0.
  - Any other address is still acked: reads return 0, writes are ignored.
- Register map:
  - 0 STATUS (RO), bits:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty;
    - [4] tx_overflow (sticky), [5] rx_underflow (sticky);
    - [31:16] rx_count, zero-extended. All other bits 0.
  - 1 CONTROL (WO, write-1 pulses, reads 0):
    - [0] tx_flush: empties TX, clears hold register.
    - [1] rx_flush: empties RX.
    - [2] clear both sticky flags.
  - 2 TX_DATA (WO, reads 0), by sel:
    - sel=0011: hold_lo<=dat_i[15:0], no push.
    - sel=1100: push {dat_i[31:16], hold_lo}.
    - sel=1111: push dat_i.
    - Any other sel: no effect.
  - 3 RX_DATA (RO):
    - wb_dat_o = RX head (full 32 bits) for every read.
    - Pop only if sel[3]=1, so a low-half read then a high-half read consumes one word.
    - If empty: return 0, no pop, set rx_underflow.
- Overflow: a push with tx_full, evaluated on the registered flag before this cycle's pops, is dropped and sets tx_overflow. It is still acked.
- Streams:
  - TX pops on tx_vld&tx_rdy. RX pushes on rx_vld&rx_rdy.
  - tx_dat is the head and is stable while tx_vld&~tx_rdy.
- Simultaneous events:
  - Push and pop in the same cycle on the same FIFO: count unchanged; both take effect.
  - Flush in the same cycle as a push or pop on that FIFO: flush wins, FIFO becomes empty.
  - Sticky-clear in the same cycle as a new overflow/underflow: the flag ends set.
- Pointers:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - Counts are DEPTH_LOG2+1 bits; full means count == 2^DEPTH_LOG2.
- Reset asserted mid-transaction: ack drops immediately, FIFOs empty. A pending bridge transaction is never acked; the bridge recovers when CE deasserts.

Test Plan:
- Reset/idle:
  - Stimulus: release rst, read STATUS.
  - Required: 0x0000_000A (tx_empty, rx_empty); ack one cycle after stb; tx_vld=0, rx_rdy=1.
- Half-word TX pack:
  - Stimulus: tx_rdy=0. Write TX_DATA sel=0011 dat=0x0000_BEEF, then sel=1100 dat=0xDEAD_0000.
  - Required: after the second ack, tx_vld=1 and tx_dat=0xDEADBEEF. Raise tx_rdy for 1 cycle -> tx_vld=0.
- TX full/overflow (DEPTH_LOG2=4):
  - Stimulus: tx_rdy=0, 17 full-word writes (0x1..0x11).
  - Required: STATUS[0]=1, STATUS[4]=1. Draining yields 0x1..0x10 in order; 0x11 absent. CONTROL write 0x4 clears bit4.
- RX read/pop and underflow:
  - Stimulus: fabric pushes 0xCAFE_F00D. Read RX_DATA sel=0011.
  - Required: 0xCAFEF00D, rx_count still 1. Then a read with sel=1100 returns 0xCAFEF00D and rx_count becomes 0. A further read returns 0 and sets STATUS[5].
- Simultaneous push/pop at full:
  - Stimulus: RX full (16 entries); hold rx_vld=1 while the host pops continuously.
  - Required: rx_rdy=0 while full. No data lost; data order preserved across pointer wrap (32+ words).
- Flush and reset mid-op:
  - Stimulus: write CONTROL=0x3 in the same cycle tx_rdy pops.
  - Required: both FIFOs empty, hold_lo=0.
  - Stimulus: assert rst while stb is high.
  - Required: wb_ack_o=0 immediately; STATUS reads 0x0000_000A after release.

Source files
------------

// File: rtl/wb_fsmc_fifo_slave.sv
// wb_fsmc_fifo_slave
// Wishbone slave that gives an external MCU (via the FSMC-to-Wishbone bridge)
// a mailbox into the fabric: a TX FIFO drained by a valid/ready stream, an RX
// FIFO filled by a valid/ready stream, plus STATUS and CONTROL registers.
// Two 16-bit TX writes (sel 0011 then 1100) are packed into one 32-bit word.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   wb_adr_i[31:0]   word-register address, only [1:0] may be non-zero
//   wb_dat_i/o       write / registered read data
//   wb_sel_i[3:0]    byte selects
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o   classic single-cycle handshake
//   tx_dat, tx_vld, tx_rdy   TX FIFO head stream towards the fabric
//   rx_dat, rx_vld, rx_rdy   RX FIFO input stream from the fabric
//
// Register map (wb_adr_i[1:0]):
//   0 STATUS  RO  [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                 [4] tx_overflow [5] rx_underflow [31:16] rx_count
//   1 CONTROL WO  [0] tx_flush [1] rx_flush [2] clear sticky flags
//   2 TX_DATA WO  sel 0011 -> hold low half, 1100 -> push {hi, hold}, 1111 -> push
//   3 RX_DATA RO  returns head; pops only when sel[3] is set
module wb_fsmc_fifo_slave #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic [31:0] tx_dat,
    output logic        tx_vld,
    input  logic        tx_rdy,
    input  logic [31:0] rx_dat,
    input  logic        rx_vld,
    output logic        rx_rdy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_TX_DATA = 2'd2;
    localparam logic [1:0] REG_RX_DATA = 2'd3;

    logic [31:0]           tx_mem [DEPTH];
    logic [31:0]           rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
    logic [15:0]           hold_lo;
    logic                  tx_ovf, rx_unf;
    logic                  alive;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        req, adr_ok, wr_acc, rd_acc;
    logic        tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic [31:0] tx_push_dat;
    logic        hold_wr, tx_flush, rx_flush, flag_clr;
    logic        rx_push, rx_pop, rx_unf_set;
    logic [31:0] rdata;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    // stb is ignored while ack is high: the bridge only drops it after ack.
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign adr_ok = (wb_adr_i[31:2] == 30'd0);
    assign wr_acc = req & wb_we_i & adr_ok;
    assign rd_acc = req & ~wb_we_i & adr_ok;

    assign tx_vld = ~tx_empty;
    assign tx_dat = tx_empty ? 32'd0 : tx_mem[tx_rd];
    // alive keeps rx_rdy low while reset is held.
    assign rx_rdy = alive & ~rx_full;

    // Register decode and read mux
    always_comb begin
        tx_push_req = 1'b0;
        tx_push_dat = 32'd0;
        hold_wr     = 1'b0;
        tx_flush    = 1'b0;
        rx_flush    = 1'b0;
        flag_clr    = 1'b0;
        rx_pop      = 1'b0;
        rx_unf_set  = 1'b0;
        rdata       = 32'd0;
        if (wr_acc) begin
            case (wb_adr_i[1:0])
                REG_CONTROL: begin
                    tx_flush = wb_dat_i[0];
                    rx_flush = wb_dat_i[1];
                    flag_clr = wb_dat_i[2];
                end
                REG_TX_DATA: begin
                    case (wb_sel_i)
                        4'b0011: hold_wr = 1'b1;
                        4'b1100: begin
                            tx_push_req = 1'b1;
                            tx_push_dat = {wb_dat_i[31:16], hold_lo};
                        end
                        4'b1111: begin
                            tx_push_req = 1'b1;
                            tx_push_dat = wb_dat_i;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        if (rd_acc) begin
            case (wb_adr_i[1:0])
                REG_STATUS: rdata = {16'(rx_cnt), 10'd0, rx_unf, tx_ovf,
                                     rx_empty, rx_full, tx_empty, tx_full};
                REG_RX_DATA: begin
                    if (rx_empty) begin
                        rx_unf_set = 1'b1;
                    end else begin
                        rdata  = rx_mem[rx_rd];
                        // Only the high-half (or full) read consumes the word.
                        rx_pop = wb_sel_i[3];
                    end
                end
                default: ;
            endcase
        end
    end

    // Fullness is judged on the registered count, before this cycle's pop.
    assign tx_push    = tx_push_req & ~tx_full;
    assign tx_ovf_set = tx_push_req & tx_full;
    assign tx_pop     = tx_vld & tx_rdy;
    assign rx_push    = rx_vld & rx_rdy;

    // Wishbone response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            alive    <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= rdata;
            alive    <= 1'b1;
        end
    end

    // TX FIFO control; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr   <= '0;
            tx_rd   <= '0;
            tx_cnt  <= '0;
            hold_lo <= 16'd0;
        end else if (tx_flush) begin
            tx_wr   <= '0;
            tx_rd   <= '0;
            tx_cnt  <= '0;
            hold_lo <= 16'd0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
            if (hold_wr) hold_lo <= wb_dat_i[15:0];
        end
    end

    // RX FIFO control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else if (rx_flush) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_push_dat;
        if (rx_push) rx_mem[rx_wr] <= rx_dat;
    end

    // Sticky flags: a new event in the clear cycle leaves the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf & ~flag_clr) | tx_ovf_set;
            rx_unf <= (rx_unf & ~flag_clr) | rx_unf_set;
        end
    end

endmodule
